// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types and constants.
// Holds opcode/state enums and the divide special-case helpers.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_DONE
  } muldiv_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam int DIV_ITERS = 32;

  // Divide by zero, or signed INT_MIN / -1.
  function automatic logic div_special(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return op[2] && ((b == 32'd0) ||
      (!op[0] && a == 32'h8000_0000 &&
       b == 32'hFFFF_FFFF));
  endfunction

  // op[1] selects remainder; op[0] selects unsigned.
  function automatic logic [31:0] div_special_res(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (b == 32'd0)
      return op[1] ? a : 32'hFFFF_FFFF;
    return op[1] ? 32'd0 : 32'h8000_0000;
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes.
// start loads operands, step retires one quotient bit, last flags bit 31.
module muldiv_div_iter
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   sh;
  logic            ge;

  // Partial remainder shifted left with the next dividend bit.
  assign sh = {rem_q, quo_q[XLEN-1]};
  assign ge = sh >= {1'b0, dvs_q};

  assign last      = cnt == CW'(DIV_ITERS - 1);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt   <= '0;
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= ge ? XLEN'(sh - {1'b0, dvs_q})
                  : sh[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], ge};
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: 2-cycle multiply, 34-cycle divide/remainder.
// Ports: valid/funct3/rs1_val/rs2_val/rd in; busy, done, result, result_rd out.
module ex_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  muldiv_state_e state, state_nx;
  muldiv_op_e    op_q;
  logic [2:0]      op_b;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      rd_q;

  logic accept, is_div_in, sgn_in, special_in;
  logic div_start, div_step, div_last;
  logic [XLEN-1:0] mag_a, mag_b, quo, rem;
  logic [XLEN-1:0] mul_res, fix_res;
  logic [XLEN:0]   a33, b33;
  logic [63:0]     prod;
  logic            q_neg, r_neg;

  assign op_b       = op_q;
  assign accept     = state == S_IDLE && valid && !flush;
  assign is_div_in  = funct3[2];
  assign sgn_in     = !funct3[0];
  assign special_in = EARLY_OUT &&
    div_special(funct3, rs1_val, rs2_val);

  // The divider works on magnitudes; signs are restored in FIXUP.
  assign mag_a = (sgn_in && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
  assign mag_b = (sgn_in && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:
          if (valid)
            state_nx = !is_div_in ? S_MUL :
                       special_in ? S_DONE : S_DIV;
        S_MUL:   state_nx = S_DONE;
        S_DIV:   if (div_last) state_nx = S_FIXUP;
        S_FIXUP: state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = accept ||
      state inside {S_MUL, S_DIV, S_FIXUP};
    done      = state == S_DONE && !flush;
    div_start = accept && is_div_in;
    div_step  = state == S_DIV && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_MUL;
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= muldiv_op_e'(funct3);
      a_q  <= rs1_val;
      b_q  <= rs2_val;
      rd_q <= rd;
    end
  end

  // 33x33 signed product covers all four multiply flavours.
  assign a33 = {(op_q != OP_MULHU) & a_q[XLEN-1], a_q};
  assign b33 = {(op_q == OP_MUL || op_q == OP_MULH) & b_q[XLEN-1], b_q};
  assign prod = 64'($signed(a33) * $signed(b33));
  assign mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

  muldiv_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .start     (div_start),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  // Divide-by-zero still needs overriding when iterated.
  assign q_neg = !op_b[0] && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg = !op_b[0] && a_q[XLEN-1];

  always_comb begin
    if (div_special(op_b, a_q, b_q))
      fix_res = div_special_res(op_b, a_q, b_q);
    else if (op_b[1])
      fix_res = r_neg ? -rem : rem;
    else
      fix_res = q_neg ? -quo : quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_rd <= '0;
    end else if (accept && is_div_in && special_in) begin
      result    <= div_special_res(funct3, rs1_val, rs2_val);
      result_rd <= rd;
    end else if (!flush && state == S_MUL) begin
      result    <= mul_res;
      result_rd <= rd_q;
    end else if (!flush && state == S_FIXUP) begin
      result    <= fix_res;
      result_rd <= rd_q;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv, run on EARLY_OUT=1 and =0 copies.
// Vector table, random ops against a model, flush and reset sequences.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush, valid;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd;
  logic        busy_w [2];
  logic        done_w [2];
  logic [31:0] res_w [2];
  logic [4:0]  rrd_w [2];

  int total = 0;
  int bad   = 0;
  logic [31:0] last_exp;
  logic [4:0]  last_rd;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .valid(valid),
    .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd(rd), .busy(busy_w[0]), .done(done_w[0]),
    .result(res_w[0]), .result_rd(rrd_w[0])
  );

  ex_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .valid(valid),
    .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd(rd), .busy(busy_w[1]), .done(done_w[1]),
    .result(res_w[1]), .result_rd(rrd_w[1])
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b, input int eo);
    if (!op[2]) return 2;
    if (eo == 1 && (b == 0 || (!op[0] &&
        a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    valid   = 1'b1;
    funct3  = op;
    rs1_val = a;
    rs2_val = b;
    rd      = r;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("busy_c0[eo%0d]", k), 32'(busy_w[k]), 32'd1);
    @(posedge clk);
    #1;
    valid   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd      = 5'($urandom);
  endtask

  task automatic do_op(input string nm, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] exp);
    int          lat [2];
    logic [31:0] got [2];
    logic [4:0]  grd [2];
    bit          seen [2];
    seen[0] = 0;
    seen[1] = 0;
    issue(op, a, b, r);
    for (int c = 1; c <= 60 && !(seen[0] && seen[1]); c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!seen[k] && done_w[k]) begin
          seen[k] = 1;
          lat[k]  = c;
          got[k]  = res_w[k];
          grd[k]  = rrd_w[k];
          chk($sformatf("%s busy_done[eo%0d]", nm, k),
              32'(busy_w[k]), 32'd0);
        end else if (!seen[k]) begin
          chk($sformatf("%s busy_run[eo%0d]", nm, k),
              32'(busy_w[k]), 32'd1);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (!seen[k]) begin
        total++;
        bad++;
        $display("FAIL %s timeout[eo%0d]: no done in 60 cycles", nm, k);
      end else begin
        chk($sformatf("%s lat[eo%0d]", nm, k),
            32'(lat[k]), 32'(exp_lat(op, a, b, k)));
        chk($sformatf("%s res[eo%0d]", nm, k), got[k], exp);
        chk($sformatf("%s rd[eo%0d]", nm, k), 32'(grd[k]), 32'(r));
      end
    end
    last_exp = exp;
    last_rd  = r;
  endtask

  vec_t vecs [$];

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0;
    funct3 = 3'd0; rs1_val = '0; rs2_val = '0; rd = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy[eo%0d]", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("rst_done[eo%0d]", k), 32'(done_w[k]), 32'd0);
      chk($sformatf("rst_res[eo%0d]", k), res_w[k], 32'd0);
      chk($sformatf("rst_rd[eo%0d]", k), 32'(rrd_w[k]), 32'd0);
    end
    rst = 1'b0;

    vecs = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
      '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{3'd5, 32'd100,        32'd7,         32'd14},
      '{3'd7, 32'd100,        32'd7,         32'd2},
      '{3'd4, 32'd12345,      32'd0,         32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFFF},
      '{3'd7, 32'd5,          32'd0,         32'd5},
      '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
      '{3'd5, 32'd77,         32'd0,         32'hFFFF_FFFF},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
      '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
      '{3'd0, 32'h0001_0000,  32'h0001_0000, 32'd0}
    };
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
            vecs[i].b, 5'(i + 1), vecs[i].res);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), op, a, b,
            5'($urandom), ref_model(op, a, b));
    end

    // Abort a divide mid-iteration.
    issue(3'd4, 32'd1000, 32'd3, 5'd9);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("fl_done[eo%0d]", k), 32'(done_w[k]), 32'd0);
        chk($sformatf("fl_busy[eo%0d]", k), 32'(busy_w[k]), 32'd0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fl_res[eo%0d]", k), res_w[k], last_exp);
      chk($sformatf("fl_rd[eo%0d]", k), 32'(rrd_w[k]), 32'(last_rd));
    end
    do_op("fl_mul", 3'd0, 32'd6, 32'd7, 5'd4, 32'd42);

    // flush together with valid in IDLE must not accept.
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; funct3 = 3'd0;
    rs1_val = 32'd3; rs2_val = 32'd3;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("fv_busy[eo%0d]", k), 32'(busy_w[k]), 32'd0);
    @(posedge clk);
    #1 valid = 1'b0; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("fv_idle[eo%0d]", k), 32'(busy_w[k]), 32'd0);
        chk($sformatf("fv_done[eo%0d]", k), 32'(done_w[k]), 32'd0);
      end
    end

    // Asynchronous reset in the middle of a divide.
    issue(3'd5, 32'd5000, 32'd7, 5'd12);
    for (int c = 1; c <= 17; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ar_busy[eo%0d]", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("ar_done[eo%0d]", k), 32'(done_w[k]), 32'd0);
      chk($sformatf("ar_res[eo%0d]", k), res_w[k], 32'd0);
      chk($sformatf("ar_rd[eo%0d]", k), 32'(rrd_w[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op("ar_divu", 3'd5, 32'd9, 32'd3, 5'd3, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands, funct3 and rd latched by ID/EX when the instruction is OP with funct7 = 0000001.
- Multiplies finish in two cycles; divides and remainders iterate over 34 cycles.
- Holds `busy` so the hazard unit stalls IF/ID and ID/EX, then drives its result into the EX-stage result mux for capture by EX/MEM.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow skip the iteration and complete in one cycle.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort (branch/jump taken in EX)
- valid  input  1  ID/EX holds an M-extension instruction
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  32  forwarded operand A
- rs2_val  input  32  forwarded operand B
- rd  input  5  destination register
- busy  output  1  stall request to the hazard unit
- done  output  1  result valid this cycle
- result  output  32  instruction result
- result_rd  output  5  destination of `result`

Behaviour:
- **Reset:** clk and rst only; rst is asynchronous and active-high. Asynchronous reset forces:
  - state = IDLE, counter = 0
  - result = 0, result_rd = 0
  - busy = 0, done = 0
- **States:** IDLE, MUL, DIV, FIXUP, DONE.
- **Accept:** in IDLE with valid=1 and flush=0. At that edge the unit latches funct3, rd and both operands.
  - MUL ops go to MUL.
  - DIV ops go to DIV.
  - With EARLY_OUT=1, rs2=0 or (signed op, rs1=0x80000000, rs2=0xFFFFFFFF) goes straight to DONE with the special result.
- **MUL state:** 33x33 signed product, operands sign- or zero-extended per op. Result register gets:
  - product[31:0] for MUL
  - product[63:32] for MULH/MULHSU/MULHU
  - next state is DONE.
- **DIV state:** restoring radix-2, one quotient bit per cycle on magnitudes, counter 0..31. The last iteration goes to FIXUP.
- **FIXUP:** applies sign rules, then goes to DONE.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- **DONE:**
  - done = 1 and flush = 0.
  - result and result_rd are stable.
  - busy = 0, so the pipeline advances at this edge.
  - Next state is IDLE unconditionally.
  - valid seen in DONE is the already-serviced instruction and is ignored.
- **busy equation:** busy = (state==IDLE & valid & ~flush) | state∈{MUL, DIV, FIXUP}. It is combinational from valid.
- **Latency:** the accept cycle is cycle 0.
  - MUL*: done in cycle 2.
  - DIV/REM: done in cycle 34.
  - Early-out: done in cycle 1.
- **Special results:**
  - Divide by zero: DIVU quotient = 0xFFFFFFFF, DIV quotient = 0xFFFFFFFF, REM/REMU = rs1.
  - Overflow: DIV = 0x80000000, REM = 0.
  - With EARLY_OUT=0, the iterative path produces the same values.
- **flush:** in any state, the next state is IDLE and counter is cleared.
  - done is gated (done = state==DONE & ~flush).
  - result and result_rd keep their old values.
  - flush together with valid in IDLE: no accept.
- **Back-to-back:** a new M instruction is accepted in the IDLE cycle following DONE, so there is no bubble beyond the one IDLE cycle.
- **Register state:** result and result_rd change only on entry to DONE (and on reset). rd = 0 is processed normally; the write is suppressed downstream.

Decomposition:
- **Shared package riscv_pkg:**
  - muldiv_op_e enum (the funct3 encodings)
  - muldiv_state_e enum
  - FUNCT7_MULDIV = 7'b0000001
  - DIV_ITERS = 32
- **Sub-module muldiv_div_iter:** the restoring-divide datapath, containing the remainder/quotient shift registers and the iteration counter, with start/step/last handshake to the parent FSM.
- **Parent block:** holds the FSM, multiplier, special cases and sign fixup.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 2, busy high in cycles 0-1.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, done in cycle 34; DIVU 100 / 7 -> 14, REMU -> 2.
4. DIV x / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5, DIV 0x80000000 / -1 -> 0x80000000, REM -> 0. With EARLY_OUT=1, done in cycle 1; with EARLY_OUT=0, done in cycle 34.
5. flush in cycle 10 of a DIV -> IDLE next cycle, no done pulse, result unchanged. A following MUL completes correctly in 2 cycles.
6. rst asserted asynchronously mid-DIV (cycle 17) -> busy, done and result go to 0 immediately; after release a DIVU 9/3 returns 3 in cycle 34.
